// File: rtl/icache_refill_ctrl.sv
// Direct-mapped, read-only instruction cache controller with 16-byte lines.
// Misses are refilled from 4-beat bridge bursts; uncached fetches bypass storage.
module icache_refill_ctrl #(
    parameter int unsigned NLINE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        uncached,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    output logic [1:0]  rd_size,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);
    localparam int unsigned IW = $clog2(NLINE);
    localparam int unsigned TW = 32 - 4 - IW;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, UNC} state_t;
    state_t state, state_nxt;

    logic [31:0]      req_addr;
    logic             req_unc;
    logic [1:0]       cnt;
    logic [NLINE-1:0] valid;
    logic [TW-1:0]    tag_arr  [NLINE];
    logic [31:0]      data_arr [NLINE][4];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [1:0]    woff;
    logic          hit;
    logic          refill_we;

    assign idx       = req_addr[4+IW-1:4];
    assign tag       = req_addr[31:4+IW];
    assign woff      = req_addr[3:2];
    assign hit       = valid[idx] && (tag_arr[idx] == tag);
    assign refill_we = (state == REFILL) && ret_valid;
    assign rd_size   = 2'b10;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= '0;
            cnt      <= '0;
            req_addr <= '0;
            req_unc  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                req_addr <= addr;
                req_unc  <= uncached;
            end
            if (state == MISS) begin
                cnt <= '0;
            end else if (refill_we) begin
                cnt <= cnt + 2'd1;
            end
            if (refill_we && ret_last) begin
                valid[idx] <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!reset && refill_we) begin
            data_arr[idx][cnt] <= ret_data;
            if (ret_last) begin
                tag_arr[idx] <= tag;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = '0;
        rd_req    = 1'b0;
        rd_type   = 3'b000;
        rd_addr   = '0;
        case (state)
            IDLE: begin
                addr_ok = req;
                if (req) begin
                    state_nxt = uncached ? MISS : LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    data_ok   = 1'b1;
                    rdata     = data_arr[idx][woff];
                    state_nxt = IDLE;
                end else begin
                    state_nxt = MISS;
                end
            end
            MISS: begin
                rd_req = 1'b1;
                if (req_unc) begin
                    rd_type = 3'b010;
                    rd_addr = req_addr;
                end else begin
                    rd_type = 3'b100;
                    rd_addr = {req_addr[31:4], 4'h0};
                end
                if (rd_rdy) begin
                    state_nxt = req_unc ? UNC : REFILL;
                end
            end
            REFILL: begin
                // Requested word is either this beat or one already written.
                if (ret_valid && ret_last) begin
                    data_ok   = 1'b1;
                    rdata     = (cnt == woff) ? ret_data : data_arr[idx][woff];
                    state_nxt = IDLE;
                end
            end
            UNC: begin
                if (ret_valid) begin
                    data_ok   = 1'b1;
                    rdata     = ret_data;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a per-cycle cache/bridge model plus
// literal expectations from hand-worked fetch scenarios.
module tb_icache_refill_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        uncached = 1'b0;
    logic        rd_rdy = 1'b0;
    logic        ret_valid = 1'b0;
    logic        ret_last = 1'b0;
    logic [31:0] ret_data = '0;
    logic        addr_ok, data_ok, rd_req;
    logic [31:0] rdata, rd_addr;
    logic [2:0]  rd_type;
    logic [1:0]  rd_size;

    int n_cmp = 0;
    int n_bad = 0;

    icache_refill_ctrl #(.NLINE(16)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .uncached(uncached),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_size(rd_size),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bridge memory image: what every beat of a given line returns.
    function automatic logic [31:0] beat_data(input logic [31:0] line, input int unsigned i);
        if (line == 32'h1C00_0000) return 32'hA0 + i;
        if (line == 32'h1FE0_0000) return 32'h55;
        return (line ^ 32'h5A5A_0000) + i;
    endfunction

    // Model: 16 lines, idx = addr[7:4], tag = addr[31:8].
    logic        m_valid [16];
    logic [23:0] m_tag   [16];
    logic        m_busy = 1'b0, m_unc = 1'b0, m_hit = 1'b0, m_grant = 1'b0;
    logic [31:0] m_addr = '0;
    int          cyc = 0, acc_cyc = 0, rst_cnt = 0;

    initial begin
        logic        exp_aok, exp_rdq, exp_dok;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (rst_cnt > 0) begin
                    check("reset_addr_ok", 32'(addr_ok), 0);
                    check("reset_data_ok", 32'(data_ok), 0);
                    check("reset_rd_req",  32'(rd_req), 0);
                    check("reset_rd_addr", rd_addr, 0);
                    check("reset_rd_type", 32'(rd_type), 0);
                    check("reset_rdata",   rdata, 0);
                end
                rst_cnt++;
                m_busy  = 1'b0;
                m_grant = 1'b0;
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            end else begin
                rst_cnt = 0;
                exp_aok = req && !m_busy;
                exp_rdq = m_busy && !m_hit && !m_grant && (cyc >= acc_cyc + (m_unc ? 1 : 2));
                exp_dok = m_busy && (m_hit ? (cyc == acc_cyc + 1)
                                           : (m_grant && ret_valid && (m_unc || ret_last)));
                check("addr_ok", 32'(addr_ok), 32'(exp_aok));
                check("rd_req",  32'(rd_req),  32'(exp_rdq));
                check("data_ok", 32'(data_ok), 32'(exp_dok));
                check("rd_size", 32'(rd_size), 2);
                if (exp_rdq) begin
                    check("rd_addr", rd_addr, m_unc ? m_addr : {m_addr[31:4], 4'h0});
                    check("rd_type", 32'(rd_type), m_unc ? 2 : 4);
                end
                if (exp_dok) begin
                    check("rdata", rdata, m_unc ? beat_data(m_addr, 0)
                                                : beat_data({m_addr[31:4], 4'h0}, 32'(m_addr[3:2])));
                    if (!m_unc && !m_hit) begin
                        m_valid[m_addr[7:4]] = 1'b1;
                        m_tag[m_addr[7:4]]   = m_addr[31:8];
                    end
                    m_busy  = 1'b0;
                    m_grant = 1'b0;
                end else if (exp_rdq && rd_rdy) begin
                    m_grant = 1'b1;
                end
                if (exp_aok) begin
                    m_busy  = 1'b1;
                    m_addr  = addr;
                    m_unc   = uncached;
                    m_hit   = !uncached && m_valid[addr[7:4]] && (m_tag[addr[7:4]] == addr[31:8]);
                    m_grant = 1'b0;
                    acc_cyc = cyc;
                end
            end
        end
    end

    // One fetch including the bridge side; rst_beat >= 0 pulses reset before that beat.
    task automatic fetch(input logic [31:0] a, input logic unc, input int stall, input int rst_beat,
                         output logic [31:0] got, output logic ok, output logic missed,
                         output logic [31:0] ra, output logic [2:0] rt);
        int n;
        int nb;
        logic [31:0] line;
        got = '0; ok = 1'b0; missed = 1'b0; ra = '0; rt = '0;
        line = unc ? a : {a[31:4], 4'h0};
        nb   = unc ? 1 : 4;
        @(posedge clk); #1;
        req = 1'b1; addr = a; uncached = unc; rd_rdy = (stall == 0);
        @(negedge clk);
        check("accept", 32'(addr_ok), 1);
        if (!addr_ok) begin
            #1 req = 1'b0; rd_rdy = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req = 1'b0; uncached = 1'b0;
        n = 0;
        @(negedge clk);
        while (!data_ok && !rd_req && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("response_timeout", 32'(data_ok || rd_req), 1);
        if (data_ok) begin
            got = rdata; ok = 1'b1;
            #1 rd_rdy = 1'b0;
            return;
        end
        if (!rd_req) begin
            #1 rd_rdy = 1'b0;
            return;
        end
        missed = 1'b1; ra = rd_addr; rt = rd_type;
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 rd_rdy = 1'b1;
        end
        @(posedge clk); #1;
        rd_rdy = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (i == rst_beat) begin
                ret_valid = 1'b0; ret_last = 1'b0;
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
            end
            ret_valid = 1'b1; ret_data = beat_data(line, i); ret_last = (i == nb - 1);
            @(negedge clk);
            if (data_ok) begin
                got = rdata; ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, ra;
        logic        ok, missed;
        logic [2:0]  rt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        fetch(32'h1C00_0004, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("cold_missed", 32'(missed), 1);
        check("cold_rd_addr", ra, 32'h1C00_0000);
        check("cold_rd_type", 32'(rt), 4);
        check("cold_ok", 32'(ok), 1);
        check("cold_rdata", got, 32'hA1);

        fetch(32'h1C00_0008, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("hit1_missed", 32'(missed), 0);
        check("hit1_rdata", got, 32'hA2);
        fetch(32'h1C00_000C, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("hit2_missed", 32'(missed), 0);
        check("hit2_rdata", got, 32'hA3);

        fetch(32'h1FE0_0000, 1'b1, 0, -1, got, ok, missed, ra, rt);
        check("unc_rd_type", 32'(rt), 2);
        check("unc_rd_addr", ra, 32'h1FE0_0000);
        check("unc_rdata", got, 32'h55);
        fetch(32'h1FE0_0000, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("unc_then_cached_missed", 32'(missed), 1);
        check("unc_then_cached_rdata", got, 32'h55);

        fetch(32'h1C00_0000, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("refill_idx0_missed", 32'(missed), 1);
        check("refill_idx0_rdata", got, 32'hA0);
        fetch(32'h1C00_0100, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("conflict_missed", 32'(missed), 1);
        check("conflict_rdata", got, 32'h465A_0100);
        fetch(32'h1C00_0000, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("evicted_missed", 32'(missed), 1);
        check("evicted_rdata", got, 32'hA0);

        fetch(32'h1C00_0018, 1'b0, 5, -1, got, ok, missed, ra, rt);
        check("stall_missed", 32'(missed), 1);
        check("stall_rd_addr", ra, 32'h1C00_0010);
        check("stall_rdata", got, 32'h465A_0012);
        fetch(32'h1C00_0014, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("stall_line_hit", 32'(missed), 0);
        check("stall_line_rdata", got, 32'h465A_0011);

        fetch(32'h1C00_0024, 1'b0, 0, 2, got, ok, missed, ra, rt);
        check("rst_mid_missed", 32'(missed), 1);
        check("rst_mid_no_data_ok", 32'(ok), 0);
        fetch(32'h1C00_0024, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("after_rst_missed", 32'(missed), 1);
        check("after_rst_rdata", got, 32'h465A_0021);
        fetch(32'h1C00_0014, 1'b0, 0, -1, got, ok, missed, ra, rt);
        check("after_rst_old_line_missed", 32'(missed), 1);
        check("after_rst_old_line_rdata", got, 32'h465A_0011);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
